// File: rtl/snake_body_tracker_if.sv
// Segment stream from the body tracker to the matrix display.
// One coordinate per beat, oldest segment first; seg_last marks the head.
interface snake_body_tracker_if;
  logic [7:0] seg_pos;
  logic       seg_valid;
  logic       seg_last;
  logic       seg_ready;

  modport master (output seg_pos, seg_valid, seg_last, input seg_ready);
  modport slave  (input seg_pos, seg_valid, seg_last, output seg_ready);
endinterface

// File: rtl/snake_body_tracker.sv
// Snake body model: checks each new head against the body, commits it to a circular buffer, and streams frames.
// Step result appears L+2 cycles after an idle step; frames stall on seg_ready and steps arriving meanwhile queue one deep.
module snake_body_tracker #(
  parameter int         MAX_LEN   = 32,
  parameter logic [7:0] START_POS = 8'h44
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         step,
  input  logic [7:0]                   headPos,
  input  logic [7:0]                   foodPos,
  snake_body_tracker_if.master         seg,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         eaten,
  output logic                         collision,
  output logic                         game_over,
  output logic                         step_drop
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT, STREAM} stateT;

  stateT          state;
  logic [7:0]     body [MAX_LEN];
  logic [PW-1:0]  hp;
  logic [PW-1:0]  tp;
  logic [PW-1:0]  idx;
  logic [7:0]     hReg;
  logic [7:0]     fReg;
  logic           hit;
  logic           pending;
  logic [7:0]     pendHead;
  logic [7:0]     pendFood;
  logic [7:0]     segPos;
  logic           segValid;
  logic           segLast;

  logic [PW-1:0]  idxNext;
  logic [PW-1:0]  hpNext;
  logic [PW-1:0]  tpNext;
  logic           onFood;
  logic           grow;
  logic           tailSkip;
  logic           bodyHit;

  assign seg.seg_pos   = segPos;
  assign seg.seg_valid = segValid;
  assign seg.seg_last  = segLast;

  always_comb begin
    idxNext  = idx + 1'b1;
    hpNext   = hp + 1'b1;
    tpNext   = tp + 1'b1;
    onFood   = (hReg == fReg);
    grow     = onFood && (length < LW'(MAX_LEN));
    // The tail slot vacates on a non-eating step, so the head may move into it.
    tailSkip = (idx == tp) && !onFood;
    bodyHit  = (body[idx] == hReg) && !tailSkip;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      body[0]   <= START_POS;
      hp        <= '0;
      tp        <= '0;
      idx       <= '0;
      hReg      <= '0;
      fReg      <= '0;
      hit       <= 1'b0;
      pending   <= 1'b0;
      pendHead  <= '0;
      pendFood  <= '0;
      segPos    <= '0;
      segValid  <= 1'b0;
      segLast   <= 1'b0;
      length    <= LW'(1);
      eaten     <= 1'b0;
      collision <= 1'b0;
      game_over <= 1'b0;
      step_drop <= 1'b0;
    end else begin
      eaten     <= 1'b0;
      collision <= 1'b0;
      step_drop <= 1'b0;

      if (step && !game_over && state != IDLE) begin
        if (pending) begin
          step_drop <= 1'b1;
        end else begin
          pending  <= 1'b1;
          pendHead <= headPos;
          pendFood <= foodPos;
        end
      end

      case (state)
        IDLE: begin
          idx <= tp;
          hit <= 1'b0;
          if (!game_over && (pending || step)) begin
            state <= CHECK;
            if (pending) begin
              hReg <= pendHead;
              fReg <= pendFood;
              // A fresh step arriving as the pending one is consumed refills the slot.
              if (step) begin
                pendHead <= headPos;
                pendFood <= foodPos;
              end else begin
                pending <= 1'b0;
              end
            end else begin
              hReg <= headPos;
              fReg <= foodPos;
            end
          end else begin
            state    <= STREAM;
            segValid <= 1'b1;
            segPos   <= body[tp];
            segLast  <= (tp == hp);
          end
        end

        CHECK: begin
          if (bodyHit) hit <= 1'b1;
          idx <= idxNext;
          if (idx == hp) state <= COMMIT;
        end

        COMMIT: begin
          if (hit) begin
            collision <= 1'b1;
            game_over <= 1'b1;
            pending   <= 1'b0;
          end else begin
            body[hpNext] <= hReg;
            hp           <= hpNext;
            eaten        <= onFood;
            if (grow) length <= length + 1'b1;
            else      tp     <= tpNext;
          end
          state <= IDLE;
        end

        STREAM: begin
          if (seg.seg_ready) begin
            if (segLast) begin
              segValid <= 1'b0;
              segLast  <= 1'b0;
              state    <= IDLE;
            end else begin
              idx     <= idxNext;
              segPos  <= body[idxNext];
              segLast <= (idxNext == hp);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
